// File: rtl/io_input_conditioner.sv
// Input conditioner for the custom I/O chip: 2-FF sync, per-bit debounce,
// per-frame latch at VBLANK onset, coin pulse shaping and UPDATE strobe.
//
// Coin FSM states (advance only on synchronised VBLANK rise)
//   state     | meaning
//   C_IDLE    | waiting for a debounced coin
//   C_ACTIVE  | coin output high, counting COIN_FRAMES frames
//   C_LOCKOUT | coin output low, counting gap frames before re-arm
module io_input_conditioner #(
    parameter int DB_COUNT    = 15,
    parameter int COIN_FRAMES = 3,
    parameter int COIN_GAP    = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic        VBLANK,
    input  logic [5:0]  RAW_P1,
    input  logic [5:0]  RAW_P2,
    input  logic        RAW_COIN,
    input  logic        RAW_START1,
    input  logic        RAW_START2,
    output logic [11:0] STKTRG12,
    output logic [2:0]  CSTART12,
    output logic        UPDATE
);

    localparam logic [7:0] DB_LIM   = 8'(DB_COUNT);
    localparam logic [3:0] CF_LIM   = 4'(COIN_FRAMES);
    localparam logic [3:0] GAP_LIM  = 4'(COIN_GAP);
    localparam logic [3:0] CNT_MAX  = 4'd15;
    localparam int         NBITS    = 15;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_ACTIVE  = 2'd1,
        C_LOCKOUT = 2'd2
    } coin_state_t;

    // bit map: [5:0] P1, [11:6] P2, [12] coin, [13] start1, [14] start2
    logic [NBITS-1:0] raw_all;
    logic [NBITS-1:0] raw_m;
    logic [NBITS-1:0] raw_s;
    logic [NBITS-1:0] stable;
    logic [7:0]       db_cnt [NBITS];
    logic             vb_m;
    logic             vb_s;
    logic             vb_d;
    logic             vb_rise;
    logic             lat_d;

    coin_state_t      coin_state;
    coin_state_t      coin_state_nxt;
    logic [3:0]       coin_cnt;
    logic [3:0]       coin_cnt_nxt;
    logic             coin_bit;
    logic             coin_stable;

    assign raw_all     = {RAW_START2, RAW_START1, RAW_COIN, RAW_P2, RAW_P1};
    assign vb_rise     = vb_s & ~vb_d;
    assign coin_stable = stable[12];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            raw_m <= '0;
            raw_s <= '0;
            vb_m  <= 1'b0;
            vb_s  <= 1'b0;
            vb_d  <= 1'b0;
        end else begin
            raw_m <= raw_all;
            raw_s <= raw_m;
            vb_m  <= VBLANK;
            vb_s  <= vb_m;
            vb_d  <= vb_s;
        end
    end

    // Commit happens on the DB_COUNT-th consecutive differing CE sample.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stable <= '0;
            for (int i = 0; i < NBITS; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else if (CE) begin
            for (int i = 0; i < NBITS; i++) begin
                if (raw_s[i] != stable[i]) begin
                    if (db_cnt[i] + 8'd1 == DB_LIM) begin
                        stable[i] <= raw_s[i];
                        db_cnt[i] <= 8'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= 8'd0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            coin_state <= C_IDLE;
            coin_cnt   <= 4'd0;
        end else if (vb_rise) begin
            coin_state <= coin_state_nxt;
            coin_cnt   <= coin_cnt_nxt;
        end
    end

    always_comb begin
        coin_state_nxt = coin_state;
        coin_cnt_nxt   = coin_cnt;
        case (coin_state)
            C_IDLE: begin
                if (coin_stable) begin
                    coin_state_nxt = C_ACTIVE;
                    coin_cnt_nxt   = 4'd1;
                end
            end
            C_ACTIVE: begin
                if (coin_cnt == CF_LIM) begin
                    coin_state_nxt = C_LOCKOUT;
                    coin_cnt_nxt   = 4'd0;
                end else begin
                    coin_cnt_nxt = coin_cnt + 4'd1;
                end
            end
            C_LOCKOUT: begin
                if (coin_cnt >= GAP_LIM && !coin_stable) begin
                    coin_state_nxt = C_IDLE;
                    coin_cnt_nxt   = 4'd0;
                end else if (coin_cnt != CNT_MAX) begin
                    coin_cnt_nxt = coin_cnt + 4'd1;
                end
            end
            default: begin
                coin_state_nxt = C_IDLE;
                coin_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Coin value latched this frame reflects the transition being taken now.
    always_comb begin
        coin_bit = 1'b0;
        case (coin_state)
            C_IDLE:   coin_bit = coin_stable;
            C_ACTIVE: coin_bit = (coin_cnt != CF_LIM);
            default:  coin_bit = 1'b0;
        endcase
    end

    // Latch reads stable before any same-cycle debounce commit lands.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            STKTRG12 <= '0;
            CSTART12 <= '0;
            lat_d    <= 1'b0;
            UPDATE   <= 1'b0;
        end else begin
            lat_d <= vb_rise;
            if (vb_rise) begin
                STKTRG12 <= stable[11:0];
                CSTART12 <= {coin_bit, stable[14:13]};
            end
            if (lat_d) begin
                UPDATE <= 1'b1;
            end else if (!vb_s) begin
                UPDATE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed bench for io_input_conditioner with a frame-level
// behavioural model compared against the outputs every cycle.
module tb_io_input_conditioner;

    localparam int DB = 15;
    localparam int CF = 3;
    localparam int CG = 4;

    logic        CLK;
    logic        RESET_N;
    logic        CE;
    logic        VBLANK;
    logic [5:0]  RAW_P1;
    logic [5:0]  RAW_P2;
    logic        RAW_COIN;
    logic        RAW_START1;
    logic        RAW_START2;
    logic [11:0] STKTRG12;
    logic [2:0]  CSTART12;
    logic        UPDATE;

    int vectors = 0;
    int errors  = 0;
    int upd_rises = 0;
    int ce_div = 0;

    io_input_conditioner #(.DB_COUNT(DB), .COIN_FRAMES(CF), .COIN_GAP(CG)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .VBLANK(VBLANK),
        .RAW_P1(RAW_P1), .RAW_P2(RAW_P2), .RAW_COIN(RAW_COIN),
        .RAW_START1(RAW_START1), .RAW_START2(RAW_START2),
        .STKTRG12(STKTRG12), .CSTART12(CSTART12), .UPDATE(UPDATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        CE = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            CE = (ce_div == 3);
            ce_div = (ce_div + 1) % 4;
        end
    end

    always @(posedge UPDATE) upd_rises++;

    // Reference model: sync delay as a two-deep history, debounce as run
    // lengths, coin as "frames since acceptance".
    logic [14:0] m_h1, m_h2, m_stab;
    int          m_run [15];
    logic        m_vb1, m_vb2, m_vbp, m_pend, m_rise, m_coin;
    int          m_since;
    logic [11:0] exp_stk;
    logic [2:0]  exp_cst;
    logic        exp_upd;

    function automatic logic coin_step(input logic c);
        int lc;
        logic o;
        o = 1'b0;
        if (m_since < 0) begin
            if (c) begin
                m_since = 1;
                o = 1'b1;
            end
        end else if (m_since < CF) begin
            m_since++;
            o = 1'b1;
        end else if (m_since == CF) begin
            m_since++;
        end else begin
            lc = m_since - CF - 1;
            if (lc > 15) lc = 15;
            if (lc >= CG && !c) m_since = -1;
            else m_since++;
        end
        return o;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_h1 = '0; m_h2 = '0; m_stab = '0;
            for (int i = 0; i < 15; i++) m_run[i] = 0;
            m_vb1 = 0; m_vb2 = 0; m_vbp = 0; m_pend = 0;
            m_since = -1;
            exp_stk = '0; exp_cst = '0; exp_upd = 1'b0;
        end else begin
            m_rise = m_vb2 && !m_vbp;
            if (m_pend) exp_upd = 1'b1;
            else if (!m_vb2) exp_upd = 1'b0;
            m_pend = m_rise;
            if (m_rise) begin
                m_coin  = coin_step(m_stab[12]);
                exp_stk = m_stab[11:0];
                exp_cst = {m_coin, m_stab[14:13]};
            end
            if (CE) begin
                for (int i = 0; i < 15; i++) begin
                    if (m_h2[i] != m_stab[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= DB) begin
                            m_stab[i] = m_h2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_vbp = m_vb2;
            m_vb2 = m_vb1;
            m_vb1 = VBLANK;
            m_h2  = m_h1;
            m_h1  = {RAW_START2, RAW_START1, RAW_COIN, RAW_P2, RAW_P1};
        end
    end

    always @(negedge CLK) begin
        vectors++;
        if (STKTRG12 !== exp_stk || CSTART12 !== exp_cst || UPDATE !== exp_upd) begin
            errors++;
            $display("FAIL model_cmp t=%0t STKTRG12=%h exp %h CSTART12=%b exp %b UPDATE=%b exp %b",
                     $time, STKTRG12, exp_stk, CSTART12, exp_cst, UPDATE, exp_upd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic frame(input int hi, input int lo);
        VBLANK = 1'b1;
        cyc(hi);
        VBLANK = 1'b0;
        cyc(lo);
    endtask

    int ones;
    int r0;
    int vbt;

    initial begin
        RESET_N = 1'b0; VBLANK = 1'b0;
        RAW_P1 = '0; RAW_P2 = '0; RAW_COIN = 1'b0; RAW_START1 = 1'b0; RAW_START2 = 1'b0;
        cyc(3);
        check("rst_stk", 32'(STKTRG12), 32'h0);
        check("rst_cst", 32'(CSTART12), 32'h0);
        check("rst_upd", 32'(UPDATE), 32'h0);
        RESET_N = 1'b1;
        cyc(5);

        // glitch shorter than DB samples is rejected
        RAW_P1[0] = 1'b1;
        cyc(40);
        RAW_P1[0] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            VBLANK = 1'b1;
            cyc(6);
            check("glitch_p1_0", 32'(STKTRG12[0]), 32'h0);
            VBLANK = 1'b0;
            cyc(20);
        end

        // stable press with exact latch/UPDATE timing
        RAW_P2[3] = 1'b1;
        cyc(90);
        VBLANK = 1'b1;
        cyc(2);
        check("press_before_latch", 32'(STKTRG12), 32'h0);
        cyc(1);
        check("press_latched", 32'(STKTRG12), 32'h200);
        check("upd_not_yet", 32'(UPDATE), 32'h0);
        cyc(1);
        check("upd_rise", 32'(UPDATE), 32'h1);
        cyc(4);
        VBLANK = 1'b0;
        cyc(2);
        check("upd_hold", 32'(UPDATE), 32'h1);
        cyc(1);
        check("upd_fall", 32'(UPDATE), 32'h0);
        RAW_P2[3] = 1'b0;
        cyc(80);

        // held coin gives one CF-frame pulse
        RAW_COIN = 1'b1;
        cyc(80);
        for (int f = 0; f < 20; f++) begin
            VBLANK = 1'b1;
            cyc(6);
            check("coin_held", 32'(CSTART12[2]), (f < CF) ? 32'h1 : 32'h0);
            VBLANK = 1'b0;
            cyc(20);
        end

        // release then re-press: exactly one more pulse
        RAW_COIN = 1'b0;
        for (int f = 0; f < 3; f++) begin
            VBLANK = 1'b1;
            cyc(6);
            check("coin_released", 32'(CSTART12[2]), 32'h0);
            VBLANK = 1'b0;
            cyc(20);
        end
        RAW_COIN = 1'b1;
        ones = 0;
        for (int f = 0; f < 10; f++) begin
            VBLANK = 1'b1;
            cyc(6);
            if (CSTART12[2]) ones++;
            VBLANK = 1'b0;
            cyc(20);
        end
        check("coin_rearm_frames", 32'(ones), 32'(CF));

        // simultaneous starts, single UPDATE edge
        RAW_START1 = 1'b1;
        RAW_START2 = 1'b1;
        cyc(80);
        r0 = upd_rises;
        VBLANK = 1'b1;
        cyc(6);
        check("starts_both", 32'(CSTART12), 32'h3);
        VBLANK = 1'b0;
        cyc(20);
        check("starts_one_edge", 32'(upd_rises - r0), 32'h1);
        RAW_START1 = 1'b0;
        RAW_START2 = 1'b0;
        RAW_COIN = 1'b0;
        cyc(80);

        // reset while UPDATE is high
        VBLANK = 1'b1;
        cyc(6);
        check("upd_before_rst", 32'(UPDATE), 32'h1);
        RESET_N = 1'b0;
        #1;
        check("rst_mid_upd", 32'(UPDATE), 32'h0);
        check("rst_mid_stk", 32'(STKTRG12), 32'h0);
        check("rst_mid_cst", 32'(CSTART12), 32'h0);
        VBLANK = 1'b0;
        cyc(3);
        RESET_N = 1'b1;
        r0 = upd_rises;
        cyc(30);
        check("no_upd_after_rst", 32'(upd_rises - r0), 32'h0);

        // randomised segments with free-running VBLANK of varied widths
        vbt = 5;
        for (int s = 0; s < 45; s++) begin
            RAW_P1     = 6'($urandom_range(0, 63));
            RAW_P2     = 6'($urandom_range(0, 63));
            RAW_COIN   = ($urandom_range(0, 2) == 0);
            RAW_START1 = ($urandom_range(0, 2) == 0);
            RAW_START2 = ($urandom_range(0, 2) == 0);
            for (int c = $urandom_range(8, 110); c > 0; c--) begin
                vbt--;
                if (vbt <= 0) begin
                    VBLANK = ~VBLANK;
                    vbt = VBLANK ? $urandom_range(1, 8) : $urandom_range(1, 30);
                end
                cyc(1);
            end
        end
        VBLANK = 1'b0;
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
